// File: rtl/memb_skew_stream.sv
// memb_skew_stream: vector FIFO feeding a diagonally skewed B-operand stream.
// Each popped vector enters a per-lane shift chain; lane r is delayed by r extra
// cycles so the array sees a diagonal wavefront. A drain counter tracks when the
// last lane has emptied and drives busy/done.
//
// Optional build macro: MEMB_SKEW_ZERO_FILL_EN
//   defined   -> Bout lanes read 0 whenever their Bvalid bit is low
//   undefined -> Bout lanes hold their last loaded value during bubbles
module memb_skew_stream #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned DIM     = 8,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              wr_en,
  input  logic signed [DIM*BITS_AB-1:0]     Bin,
  input  logic                              rd_en,
  output logic signed [DIM*BITS_AB-1:0]     Bout,
  output logic [DIM-1:0]                    Bvalid,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              busy,
  output logic                              done,
  output logic                              ovf,
  output logic                              udf
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);
  localparam int unsigned DrnW = $clog2(DIM+1);
  localparam int unsigned VecW = DIM * BITS_AB;

  // Observable streaming phase; the drain counter is the underlying state.
  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain
  } phase_e;

  logic [VecW-1:0] mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [DrnW-1:0] drain_q, drain_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            pop, push, pop_eff, push_eff;
  logic [VecW-1:0] head;
  phase_e          phase;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

  // A full FIFO may still accept a write when a pop frees a slot in the same cycle.
  assign pop      = rd_en & ~empty;
  assign push     = wr_en & (~full | pop);
  // flush overrides both data movements.
  assign pop_eff  = pop & ~flush;
  assign push_eff = push & ~flush;

  assign head = mem[rd_ptr_q];

  // Occupancy, error flags and drain counter next-state.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    drain_d = drain_q;
    if (flush) begin
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
      drain_d = '0;
    end else begin
      unique case ({push_eff, pop_eff})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      if (wr_en & full & ~pop) ovf_d = 1'b1;
      if (rd_en & empty)       udf_d = 1'b1;
      if (pop_eff) begin
        drain_d = DrnW'(DIM);
      end else if (drain_q != '0) begin
        drain_d = drain_q - DrnW'(1);
      end
    end
  end

  // Control state: pointers, occupancy, sticky errors, drain counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      drain_q  <= '0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      drain_q <= drain_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_eff) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop_eff)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Vector storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr_q] <= Bin;
  end

  // Phase decode and drain status outputs.
  always_comb begin
    phase = StIdle;
    if (pop) begin
      phase = StStream;
    end else if (drain_q != '0) begin
      phase = StDrain;
    end
    busy = (drain_q != '0);
    // Counter reaches 1 exactly on the final valid cycle of lane DIM-1.
    done = (phase == StDrain) && (drain_q == DrnW'(1));
  end

  for (genvar r = 0; r < DIM; r++) begin : g_lane
    localparam int unsigned LaneW = r + 1;

    logic [BITS_AB-1:0] data_q [LaneW];
    logic [r:0]         vld_q;

    // Lane shift chain of r+1 stages; data only advances with its valid bit so
    // the output register holds its value through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= r; j++) data_q[j] <= '0;
        vld_q <= '0;
      end else begin
        vld_q <= flush ? '0 : ((vld_q << 1) | LaneW'(pop_eff));
        if (pop_eff) data_q[0] <= head[r*BITS_AB +: BITS_AB];
        for (int j = 1; j <= r; j++) begin
          if (vld_q[j-1]) data_q[j] <= data_q[j-1];
        end
      end
    end

    assign Bvalid[r] = vld_q[r];
`ifdef MEMB_SKEW_ZERO_FILL_EN
    assign Bout[r*BITS_AB +: BITS_AB] = vld_q[r] ? data_q[r] : '0;
`else
    assign Bout[r*BITS_AB +: BITS_AB] = data_q[r];
`endif
  end

endmodule

// File: tb/tb_memb_skew_stream.sv
// Scoreboard bench for memb_skew_stream (DIM=4, DEPTH=4, BITS_AB=8).
// Stimulus pushes per-lane expected values when a pop is issued; a negedge
// monitor pops and compares whenever a lane presents valid data.
module tb_memb_skew_stream;

  localparam int DIM   = 4;
  localparam int DEPTH = 4;
  localparam int BW    = 8;

  logic                    clk;
  logic                    rst_n;
  logic                    flush;
  logic                    wr_en;
  logic signed [DIM*BW-1:0] Bin;
  logic                    rd_en;
  logic signed [DIM*BW-1:0] Bout;
  logic [DIM-1:0]          Bvalid;
  logic                    full;
  logic                    empty;
  logic [2:0]              count;
  logic                    busy;
  logic                    done;
  logic                    ovf;
  logic                    udf;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mdl_q [$];
  logic [7:0]  exp_q [DIM][$];
  logic [7:0]  mon_exp;

  memb_skew_stream #(
    .BITS_AB (BW),
    .DIM     (DIM),
    .DEPTH   (DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .wr_en  (wr_en),
    .Bin    (Bin),
    .rd_en  (rd_en),
    .Bout   (Bout),
    .Bvalid (Bvalid),
    .full   (full),
    .empty  (empty),
    .count  (count),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .udf    (udf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; expected lane data is queued when the pop commits.
  task automatic step(input logic w, input logic [31:0] v, input logic r, input logic f);
    bit          p;
    bit          pu;
    logic [31:0] tmp;
    p  = r && (mdl_q.size() > 0) && !f;
    pu = w && ((mdl_q.size() < DEPTH) || p) && !f;
    wr_en = w;
    Bin   = v;
    rd_en = r;
    flush = f;
    @(posedge clk);
    if (f) begin
      mdl_q.delete();
      for (int i = 0; i < DIM; i++) exp_q[i].delete();
    end else begin
      if (p) begin
        tmp = mdl_q.pop_front();
        for (int i = 0; i < DIM; i++) exp_q[i].push_back(tmp[i*8 +: 8]);
      end
      if (pu) mdl_q.push_back(v);
    end
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    Bin   = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Monitor: every valid lane must match the oldest expected value for that lane.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int r = 0; r < DIM; r++) begin
        if (Bvalid[r]) begin
          if (exp_q[r].size() == 0) begin
            chk($sformatf("lane%0d_unexpected_valid", r), 32'(Bvalid[r]), 32'h0);
          end else begin
            mon_exp = exp_q[r].pop_front();
            chk($sformatf("lane%0d_data", r), 32'(Bout[r*8 +: 8]), 32'(mon_exp));
          end
        end
      end
    end
  end

  logic [7:0] bub0, bub1, bub2;

  initial begin
`ifdef MEMB_SKEW_ZERO_FILL_EN
    bub0 = 8'h00; bub1 = 8'h00; bub2 = 8'h00;
`else
    bub0 = 8'h81; bub1 = 8'h82; bub2 = 8'h83;
`endif
    rst_n = 1'b0;
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    Bin   = '0;
    #3;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_bvalid", 32'(Bvalid), 0);
    chk("rst_bout", Bout, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_udf", 32'(udf), 0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: two vectors, back-to-back pops
    step(1'b1, 32'h04030201, 1'b0, 1'b0);
    step(1'b1, 32'h08070605, 1'b0, 1'b0);
    chk("t1_count2", 32'(count), 2);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t1_c1_bvalid", 32'(Bvalid), 32'h1);
    chk("t1_c1_lane0", 32'(Bout[7:0]), 1);
    chk("t1_c1_busy", 32'(busy), 1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t1_c2_bvalid", 32'(Bvalid), 32'h3);
    chk("t1_c2_lane0", 32'(Bout[7:0]), 5);
    chk("t1_c2_lane1", 32'(Bout[15:8]), 2);
    idle(1);
    chk("t1_c3_bvalid", 32'(Bvalid), 32'h6);
    idle(1);
    chk("t1_c4_bvalid", 32'(Bvalid), 32'hc);
    chk("t1_c4_lane3", 32'(Bout[31:24]), 4);
    chk("t1_c4_done", 32'(done), 0);
    idle(1);
    chk("t1_c5_bvalid", 32'(Bvalid), 32'h8);
    chk("t1_c5_lane3", 32'(Bout[31:24]), 8);
    chk("t1_c5_done", 32'(done), 1);
    chk("t1_c5_busy", 32'(busy), 1);
    idle(1);
    chk("t1_c6_bvalid", 32'(Bvalid), 0);
    chk("t1_c6_busy", 32'(busy), 0);
    chk("t1_c6_done", 32'(done), 0);
    chk("t1_c6_empty", 32'(empty), 1);

    // 2: full FIFO, dropped write, simultaneous write+pop
    step(1'b1, 32'h13121110, 1'b0, 1'b0);
    step(1'b1, 32'h23222120, 1'b0, 1'b0);
    step(1'b1, 32'h33323130, 1'b0, 1'b0);
    step(1'b1, 32'h43424140, 1'b0, 1'b0);
    chk("t2_count4", 32'(count), 4);
    chk("t2_full", 32'(full), 1);
    step(1'b1, 32'h53525150, 1'b0, 1'b0);
    chk("t2_ovf", 32'(ovf), 1);
    chk("t2_count_drop", 32'(count), 4);
    step(1'b1, 32'h63626160, 1'b1, 1'b0);
    chk("t2_count_wr_rd", 32'(count), 4);
    chk("t2_full_wr_rd", 32'(full), 1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    idle(5);
    chk("t2_empty", 32'(empty), 1);
    chk("t2_ovf_sticky", 32'(ovf), 1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t2_ovf_flushed", 32'(ovf), 0);

    // 3: underflow and no same-cycle bypass
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t3_udf", 32'(udf), 1);
    chk("t3_bvalid", 32'(Bvalid), 0);
    chk("t3_busy", 32'(busy), 0);
    step(1'b1, 32'h74737271, 1'b1, 1'b0);
    chk("t3_count_nobypass", 32'(count), 1);
    chk("t3_bvalid_nobypass", 32'(Bvalid), 0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t3_pop_bvalid", 32'(Bvalid), 32'h1);
    chk("t3_pop_lane0", 32'(Bout[7:0]), 32'h71);
    chk("t3_pop_count", 32'(count), 0);
    idle(5);
    chk("t3_udf_sticky", 32'(udf), 1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t3_udf_flushed", 32'(udf), 0);

    // 4: pop, bubble, pop
    step(1'b1, 32'h84838281, 1'b0, 1'b0);
    step(1'b1, 32'h94939291, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t4_c1_bvalid", 32'(Bvalid), 32'h1);
    idle(1);
    chk("t4_c2_bvalid", 32'(Bvalid), 32'h2);
    chk("t4_c2_lane0_bubble", 32'(Bout[7:0]), 32'(bub0));
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t4_c3_bvalid", 32'(Bvalid), 32'h5);
    chk("t4_c3_lane0", 32'(Bout[7:0]), 32'h91);
    chk("t4_c3_lane1_bubble", 32'(Bout[15:8]), 32'(bub1));
    idle(1);
    chk("t4_c4_bvalid", 32'(Bvalid), 32'ha);
    chk("t4_c4_lane2_bubble", 32'(Bout[23:16]), 32'(bub2));
    idle(5);

    // 5: flush mid-drain with ovf set
    step(1'b1, 32'hA3A2A1A0, 1'b0, 1'b0);
    step(1'b1, 32'hB3B2B1B0, 1'b0, 1'b0);
    step(1'b1, 32'hC3C2C1C0, 1'b0, 1'b0);
    step(1'b1, 32'hD3D2D1D0, 1'b0, 1'b0);
    step(1'b1, 32'hE3E2E1E0, 1'b0, 1'b0);
    chk("t5_ovf", 32'(ovf), 1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    idle(1);
    chk("t5_pre_flush_done", 32'(done), 0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t5_bvalid", 32'(Bvalid), 0);
    chk("t5_count", 32'(count), 0);
    chk("t5_ovf_clr", 32'(ovf), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_empty", 32'(empty), 1);
    for (int i = 0; i < 6; i++) begin
      chk("t5_no_done", 32'(done), 0);
      idle(1);
    end

    // 6: asynchronous reset mid-drain, then resume
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t6_udf", 32'(udf), 1);
    step(1'b1, 32'hF4F3F2F1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_bvalid", 32'(Bvalid), 0);
    chk("t6_rst_bout", Bout, 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_udf", 32'(udf), 0);
    chk("t6_rst_empty", 32'(empty), 1);
    mdl_q.delete();
    for (int i = 0; i < DIM; i++) exp_q[i].delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'h14131211, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    idle(2);
    chk("t6_c3_done", 32'(done), 0);
    idle(1);
    chk("t6_c4_done", 32'(done), 1);
    chk("t6_c4_bvalid", 32'(Bvalid), 32'h8);
    chk("t6_c4_lane3", 32'(Bout[31:24]), 32'h14);
    idle(2);
    chk("t6_busy_end", 32'(busy), 0);

    for (int i = 0; i < DIM; i++) begin
      chk($sformatf("lane%0d_leftover", i), 32'(exp_q[i].size()), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memb_skew_stream.md
Name: memb_skew_stream

Overview:
- Parametrised successor to the systolic B-operand buffer.
- Holds up to DEPTH full B vectors (DIM lanes each) in a shared vector FIFO.
- On each accepted pop, presents the vector to the array with diagonal skew: lane r appears r cycles after lane 0. Per-lane valid flags, occupancy, error flags, flush and drain tracking are provided.

Parameters:
- BITS_AB, 8, signed element width.
- DIM, 8, lane count (array dimension), >=2.
- DEPTH, 8, vector FIFO entries, power of two, >=2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- flush  in  1  sync clear of FIFO, skew pipeline, drain state, errors.
- wr_en  in  1  push Bin as one vector.
- Bin  in  [BITS_AB-1:0] x DIM, signed  write vector.
- rd_en  in  1  request pop of the oldest vector into the skew pipeline.
- Bout  out  [BITS_AB-1:0] x DIM, signed  skewed lane outputs.
- Bvalid  out  DIM  per-lane valid.
- full  out  1  FIFO count == DEPTH.
- empty  out  1  FIFO count == 0.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.
- busy  out  1  skew pipeline holds any valid lane data.
- done  out  1  one-cycle pulse on the last valid cycle of lane DIM-1.
- ovf  out  1  sticky: write dropped.
- udf  out  1  sticky: pop requested while empty.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: pointers, count, skew registers, Bvalid, busy, done, ovf and udf are all 0. Bout is 0.
- Pop:
  - pop = rd_en & !empty.
  - Reads the head vector and advances the read pointer.
- Push:
  - push = wr_en & (!full | pop).
  - A write into a full FIFO succeeds only in the same cycle as a pop.
  - No write-to-read bypass: a push into an empty FIFO is poppable the next cycle at the earliest.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. Wraps pointers modulo DEPTH.
- Skew pipeline:
  - Lane r is a shift chain of r+1 registers, each with a valid bit.
  - The stage-0 valid bit is loaded with pop.
  - If the head vector is popped at edge T:
    - lane r data and Bvalid[r] are presented during the cycle following edge T+r;
    - i.e. lane 0 appears 1 cycle after the pop, lane DIM-1 appears DIM cycles after.
  - Back-to-back pops yield a continuous diagonal wavefront. Gaps in rd_en propagate as invalid bubbles per lane.
- Drain counter:
  - Loaded with DIM on every pop; otherwise decrements to 0.
  - busy = (counter != 0).
  - done = (counter == 1) & !pop. This is exactly the last cycle lane DIM-1 carries valid data.
- State view:
  - IDLE: counter = 0.
  - STREAM: pop this cycle.
  - DRAIN: counter > 0, no pop.
  - Transitions: IDLE->STREAM on pop; STREAM->DRAIN when pops stop; DRAIN->STREAM on pop; DRAIN->IDLE when the counter reaches 0.
- Error flags:
  - ovf sets when wr_en & full & !pop.
  - udf sets when rd_en & empty.
  - Both stay set until flush or reset.
- flush:
  - Takes priority over push and pop in the same cycle.
  - Next cycle: count = 0, all Bvalid = 0, busy = 0, ovf = udf = 0.
  - No done pulse is produced for flushed data.
- Reset mid-stream: outputs clear immediately (async). Partial wavefronts are discarded.

Optional Feature:
- Macro: MEMB_SKEW_ZERO_FILL_EN.
- Defined: Bout[r] = 0 whenever Bvalid[r] = 0, so the array sees zeros in bubbles.
- Undefined: Bout[r] is the raw lane register and holds its last value during bubbles. Consumers must qualify with Bvalid.
- Bvalid, busy and done are identical in both builds.

Test Plan (DIM=4, DEPTH=4, BITS_AB=8):
1. Reset, then push vectors {1,2,3,4} and {5,6,7,8}; count=2. Pop 2 consecutive cycles:
   - lane0 shows 1,5 in cycles T+1,T+2;
   - lane3 shows 4,8 in cycles T+4,T+5;
   - done pulses in cycle T+5; busy low from T+6.
2. Fill 4 vectors (full=1), then wr_en without rd_en -> vector dropped, ovf=1, count stays 4. Next, wr_en & rd_en together -> push accepted, count stays 4.
3. From empty, rd_en=1 -> no Bvalid, udf=1. A push in the same cycle is not popped until the next cycle.
4. Pop, idle 1 cycle, pop (vectors A,B) -> each lane shows A, a bubble, then B. Bout=0 in the bubble with MEMB_SKEW_ZERO_FILL_EN; holds A without it.
5. flush asserted 2 cycles after a 3-vector burst with ovf set -> next cycle all Bvalid=0, count=0, ovf=0, and no done pulse.
6. Assert rst_n=0 asynchronously mid-drain -> all outputs 0 without waiting for a clk edge. Resume with one pop -> normal skew, done at T+4.
